sap1_out_port_tx: RTL and testbench
===================================

Name: sap1_out_port_tx

Overview:
- SAP-1 output port, transmit side.
- Captures a W-bus word into an output register when LOAD is asserted and presents it in parallel on R for the display.
- Serialises the same word on SDO as an asynchronous-style frame (start, LSB-first data, stop), with a BUSY status and a sticky overrun flag.
- Sits after the accumulator on the W-bus; the controller-sequencer drives LOAD.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- BIT_CYC, 4, CLK cycles per serial bit (>=1).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- LOAD  input  1  capture W into R and start a frame; active-high.
- W  input  WIDTH  W-bus data.
- R  output  WIDTH  parallel output register (display value).
- SDO  output  1  serial data out; idle level 1.
- BUSY  output  1  high while a frame is in progress.
- OVR  output  1  sticky overrun flag.

Behaviour:
- Reset (CLR=0 at a rising edge) takes priority over everything.
  - R=0, SDO=1, BUSY=0, OVR=0.
  - FSM goes to IDLE; bit counter and cycle counter are cleared.
  - Reset mid-frame aborts the frame immediately. SDO=1 from the next edge.
- R update rule, per edge: R <= LOAD ? W : R.
  - R loads whenever LOAD=1, including while BUSY, so the display always shows the latest W.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE
  - SDO=1.
  - On LOAD=1: latch W into the shift register and go to START.
  - BUSY=1 from the next edge. Latency from the LOAD edge to the SDO falling edge is 1 cycle.
- START: SDO=0 for BIT_CYC cycles, then go to DATA.
- DATA
  - SDO = shift[0] for BIT_CYC cycles per bit, LSB first, WIDTH bits.
  - The shift register shifts right at the end of each bit.
  - After bit WIDTH-1, go to STOP.
- STOP: SDO=1 for BIT_CYC cycles, then go to IDLE. BUSY=0 on the same edge.
- Total frame length is (WIDTH+2)*BIT_CYC cycles (plus BIT_CYC with parity).
- LOAD=1 while BUSY=1 (any state except IDLE):
  - The frame in flight is unaffected.
  - OVR is set on that edge and stays set until reset.
  - R still updates.
- LOAD=1 on the same edge that STOP completes: counts as overrun. The FSM returns to IDLE; no back-to-back frame is started.
- LOAD held high in IDLE starts exactly one frame. Continued high while busy sets OVR.
- Counters
  - Cycle counter is $clog2(BIT_CYC) bits wide (minimum 1) and wraps to 0 at BIT_CYC-1.
  - Bit counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SAP1_OUT_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - SDO = XOR of all latched data bits (even parity) for BIT_CYC cycles.
  - Frame length becomes (WIDTH+3)*BIT_CYC.
- Undefined: no PARITY state; DATA goes directly to STOP.

Decomposition:
- Package sap1_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam SDO_IDLE = 1'b1.
- One natural sub-module, sap1_bit_timer.
  - Counts BIT_CYC cycles and emits a one-cycle tick.
  - Synchronous active-low CLR plus a restart input.
- The top instantiates the timer and holds the FSM, shift register, R and OVR.

Test Plan:
1. Reset: hold CLR=0 for 2 cycles with LOAD=1, W=8'hFF -> R=0, SDO=1, BUSY=0, OVR=0 throughout.
2. Frame: WIDTH=8, BIT_CYC=4, single-cycle LOAD with W=8'hA5.
   - R=8'hA5 next edge; BUSY=1 for 40 cycles.
   - SDO samples per bit: 0,1,0,1,0,0,1,0,1,1; then idle 1.
3. Overrun: LOAD with W=8'h3C, then LOAD with W=8'h81 at cycle 10.
   - R=8'h81 and OVR=1.
   - SDO still carries 8'h3C; no second frame follows.
4. Reset mid-frame: CLR=0 at cycle 15 of a frame -> next edge SDO=1, BUSY=0, R=0, OVR=0. A new LOAD then starts a clean frame.
5. Held LOAD: LOAD=1 for 50 cycles with W=8'h01 -> exactly one frame, OVR=1.
6. Parity (SAP1_OUT_PARITY_EN defined): W=8'h07 -> parity bit 1, frame 44 cycles. W=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 output port transmitter.
// No logic, so no latency.
// No flow control.
package sap1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic SDO_IDLE = 1'b1;

endpackage

// File: rtl/sap1_bit_timer.sv
// Serial bit timer: counts BIT_CYC clock cycles and flags the last one with tick.
// tick is decoded from the count register, so the first tick comes BIT_CYC-1 cycles after a restart.
// No flow control. restart holds the count at 0; CLR is synchronous and active-low.
module sap1_bit_timer #(
  parameter int BIT_CYC = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The last cycle of a bit is the one where the count reaches BIT_CYC-1.
  assign tick = (cnt_q == CW'(BIT_CYC - 1));

  // Next count: hold at 0 on restart, wrap to 0 after the last cycle of a bit, else increment.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sap1_out_port_tx.sv
// SAP-1 output port: latches W into R on LOAD and sends the word on SDO as a start/data(LSB-first)/stop frame. Optional even parity bit: SAP1_OUT_PARITY_EN.
// R updates one cycle after LOAD; SDO falls for the start bit one cycle after the LOAD that starts a frame.
// No backpressure: a LOAD while BUSY still updates R but does not start a frame; it sets the sticky OVR flag.
module sap1_out_port_tx
  import sap1_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BIT_CYC = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] R,
  output logic             SDO,
  output logic             BUSY,
  output logic             OVR
);

  localparam int BW = $clog2(WIDTH);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             sdo_q,   sdo_d;
  logic             busy_q,  busy_d;
  logic             ovr_q,   ovr_d;
  logic             load_q,  load_d;
  logic             par_q,   par_d;
  logic             tick;
  logic             start;

  // The timer is held at 0 while idle, so the start bit always gets a full BIT_CYC cycles.
  sap1_bit_timer #(
    .BIT_CYC (BIT_CYC)
  ) u_timer (
    .clk     (CLK),
    .clr_n   (CLR),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  // Start only on a rising LOAD, so a LOAD held across the end of a frame cannot start another one.
  assign start = LOAD && !load_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    load_d  = LOAD;
    r_d     = LOAD ? W : r_q;
    ovr_d   = ovr_q;

    if (LOAD && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          shift_d = W;
          bit_d   = '0;
          par_d   = ^W;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d = '0;
`ifdef SAP1_OUT_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef SAP1_OUT_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered without an extra cycle.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   sdo_d = 1'b0;
      DATA:    sdo_d = shift_d[0];
      PARITY:  sdo_d = par_d;
      default: sdo_d = SDO_IDLE;
    endcase
  end

  // State and output registers; CLR low aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      load_q  <= 1'b0;
      r_q     <= '0;
      sdo_q   <= SDO_IDLE;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      load_q  <= load_d;
      r_q     <= r_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign R    = r_q;
  assign SDO  = sdo_q;
  assign BUSY = busy_q;
  assign OVR  = ovr_q;

endmodule

// File: tb/tb_sap1_out_port_tx.sv
// Directed bench for sap1_out_port_tx (WIDTH=8, BIT_CYC=4).
// Outputs are sampled 1 time unit after each rising edge.
// Define SAP1_OUT_PARITY_EN to exercise the parity frames.
module tb_sap1_out_port_tx;

  localparam int WIDTH   = 8;
  localparam int BIT_CYC = 4;
`ifdef SAP1_OUT_PARITY_EN
  localparam int FL = (WIDTH + 3) * BIT_CYC;
`else
  localparam int FL = (WIDTH + 2) * BIT_CYC;
`endif

  logic             CLK = 1'b0;
  logic             CLR;
  logic             LOAD;
  logic [WIDTH-1:0] W;
  logic [WIDTH-1:0] R;
  logic             SDO;
  logic             BUSY;
  logic             OVR;

  int checks   = 0;
  int failures = 0;

  sap1_out_port_tx #(
    .WIDTH   (WIDTH),
    .BIT_CYC (BIT_CYC)
  ) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .LOAD (LOAD),
    .W    (W),
    .R    (R),
    .SDO  (SDO),
    .BUSY (BUSY),
    .OVR  (OVR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] er, input logic es,
                         input logic eb, input logic eo);
    chk({tag, "_R"},    32'(R),    32'(er));
    chk({tag, "_SDO"},  32'(SDO),  32'(es));
    chk({tag, "_BUSY"}, 32'(BUSY), 32'(eb));
    chk({tag, "_OVR"},  32'(OVR),  32'(eo));
  endtask

  // Expected line level for frame slot s: 0 start, 1..8 data LSB first, then parity/stop.
  function automatic logic exp_sdo(input logic [7:0] w, input int s);
    if (s == 0) return 1'b0;
    if (s <= WIDTH) return w[s-1];
`ifdef SAP1_OUT_PARITY_EN
    if (s == WIDTH + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Frame starting from idle: LOAD at k=1..hold and again at k=l2 (0 = never) with word w2.
  task automatic run_frame(input string tag, input logic [7:0] w, input logic [7:0] w2,
                           input int l2, input int hold);
    int   last;
    logic [7:0] er;
    logic es, eb, eo;
    last = ((hold > FL) ? hold : FL) + 6;
    for (int k = 1; k <= last; k++) begin
      LOAD = (k <= hold) || (k == l2);
      W    = (l2 != 0 && k >= l2) ? w2 : w;
      tick();
      LOAD = 1'b0;
      er = (l2 != 0 && k >= l2) ? w2 : w;
      eo = (hold >= 2 && k >= 2) || (l2 != 0 && k >= l2);
      eb = (k <= FL);
      es = (k <= FL) ? exp_sdo(w, (k - 1) / BIT_CYC) : 1'b1;
      chk_all($sformatf("%s_k%0d", tag, k), er, es, eb, eo);
    end
  endtask

  initial begin
    // Reset with LOAD asserted: nothing may escape.
    CLR  = 1'b0;
    LOAD = 1'b1;
    W    = 8'hFF;
    tick();
    chk_all("rst_c1", 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("rst_c2", 8'h00, 1'b1, 1'b0, 1'b0);
    CLR  = 1'b1;
    LOAD = 1'b0;
    tick();
    chk_all("idle", 8'h00, 1'b1, 1'b0, 1'b0);

    // Single frame of 0xA5: 0,1,0,1,0,0,1,0,1,1.
    run_frame("a5", 8'hA5, 8'h00, 0, 1);

    // Overrun at cycle 10: R follows, frame for 0x3C continues, no second frame.
    run_frame("ovr", 8'h3C, 8'h81, 10, 1);

    // Reset in the middle of a frame.
    LOAD = 1'b1;
    W    = 8'hC3;
    tick();
    LOAD = 1'b0;
    for (int k = 2; k <= 14; k++) tick();
    chk("mid_busy_before", 32'(BUSY), 32'(1));
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    chk_all("mid_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mid_rst_idle", 8'h00, 1'b1, 1'b0, 1'b0);
    run_frame("clean", 8'h5A, 8'h00, 0, 1);

    // LOAD held for 50 cycles: one frame, OVR set.
    run_frame("hold", 8'h01, 8'h00, 0, 50);

`ifdef SAP1_OUT_PARITY_EN
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    chk_all("par_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    run_frame("par07", 8'h07, 8'h00, 0, 1);
    run_frame("par03", 8'h03, 8'h00, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
